rgb565_tmds_encoder: RTL and testbench



---
 rtl/rgb565_tmds_encoder.sv | 147 ++++++++++++++
 tb/tb_rgb565_tmds_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb565_tmds_encoder.sv
// RGB565 pixel stream to three DVI/TMDS 10-bit symbols, each channel with its own running disparity.
// Latency is a fixed 3 clocks for data and control alike; the pipeline is free-running with no backpressure.
module rgb565_tmds_encoder #(
  parameter bit EXPAND_MODE = 1'b1,
  parameter bit HS_INVERT   = 1'b0,
  parameter bit VS_INVERT   = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic [15:0] video_rgb,
  output logic [9:0]  tmds_ch0,
  output logic [9:0]  tmds_ch1,
  output logic [9:0]  tmds_ch2,
  output logic        tmds_valid
);

  // Transition-minimising stage: q_m[8]=1 marks the XOR chain, 0 the XNOR chain.
  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'd0, d[i]};
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    return qm;
  endfunction

  // Returns {next_cnt[4:0], symbol[9:0]}; cnt is 5-bit two's complement.
  function automatic logic [14:0] sym_encode(input logic       de,
                                             input logic       c1,
                                             input logic       c0,
                                             input logic [8:0] qm,
                                             input logic [4:0] cnt);
    logic [3:0] n1;
    logic [4:0] diff;
    logic [4:0] cnt_nx;
    logic [9:0] sym;
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'd0, qm[i]};
    diff   = {n1, 1'b0} - 5'd8;  // n1 - n0
    cnt_nx = 5'd0;
    sym    = 10'd0;
    if (!de) begin
      case ({c1, c0})
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      cnt_nx = 5'd0;
    end else if ((cnt == 5'd0) || (n1 == 4'd4)) begin
      sym    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_nx = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[4] && (n1 > 4'd4)) || (cnt[4] && (n1 < 4'd4))) begin
      sym    = {1'b1, qm[8], ~qm[7:0]};
      cnt_nx = cnt + {3'd0, qm[8], 1'b0} - diff;
    end else begin
      sym    = {1'b0, qm[8], qm[7:0]};
      cnt_nx = cnt + diff - (qm[8] ? 5'd0 : 5'd2);
    end
    return {cnt_nx, sym};
  endfunction

  logic            s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic [2:0][7:0] s1_col_q, s1_col_d;
  logic            s2_de_q, s2_de_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
  logic [2:0][8:0] s2_qm_q, s2_qm_d;
  logic [2:0][9:0] ch_q, ch_d;
  logic [2:0][4:0] cnt_q, cnt_d;
  logic [1:0]      fill_q, fill_d;
  logic            valid_q, valid_d;

  always_comb begin
    s1_de_d = video_de;
    s1_hs_d = video_hs ^ HS_INVERT;
    s1_vs_d = video_vs ^ VS_INVERT;
    // Index 0 = blue, 1 = green, 2 = red, matching the output channel numbering.
    if (EXPAND_MODE) begin
      s1_col_d[2] = {video_rgb[15:11], video_rgb[15:13]};
      s1_col_d[1] = {video_rgb[10:5],  video_rgb[10:9]};
      s1_col_d[0] = {video_rgb[4:0],   video_rgb[4:2]};
    end else begin
      s1_col_d[2] = {video_rgb[15:11], 3'b000};
      s1_col_d[1] = {video_rgb[10:5],  2'b00};
      s1_col_d[0] = {video_rgb[4:0],   3'b000};
    end

    s2_de_d = s1_de_q;
    s2_hs_d = s1_hs_q;
    s2_vs_d = s1_vs_q;
    for (int c = 0; c < 3; c++) s2_qm_d[c] = qm_encode(s1_col_q[c]);

    {cnt_d[0], ch_d[0]} = sym_encode(s2_de_q, s2_vs_q, s2_hs_q, s2_qm_q[0], cnt_q[0]);
    {cnt_d[1], ch_d[1]} = sym_encode(s2_de_q, 1'b0, 1'b0, s2_qm_q[1], cnt_q[1]);
    {cnt_d[2], ch_d[2]} = sym_encode(s2_de_q, 1'b0, 1'b0, s2_qm_q[2], cnt_q[2]);

    fill_d  = fill_q;
    valid_d = valid_q;
    if (!valid_q) begin
      if (fill_q == 2'd2) valid_d = 1'b1;
      else                fill_d  = fill_q + 2'd1;
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_de_q  <= 1'b0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_col_q <= '0;
      s2_de_q  <= 1'b0;
      s2_hs_q  <= 1'b0;
      s2_vs_q  <= 1'b0;
      s2_qm_q  <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      fill_q   <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      s1_de_q  <= s1_de_d;
      s1_hs_q  <= s1_hs_d;
      s1_vs_q  <= s1_vs_d;
      s1_col_q <= s1_col_d;
      s2_de_q  <= s2_de_d;
      s2_hs_q  <= s2_hs_d;
      s2_vs_q  <= s2_vs_d;
      s2_qm_q  <= s2_qm_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
    end
  end

  assign tmds_ch0   = ch_q[0];
  assign tmds_ch1   = ch_q[1];
  assign tmds_ch2   = ch_q[2];
  assign tmds_valid = valid_q;

endmodule

// File: tb/tb_rgb565_tmds_encoder.sv
// Bench for rgb565_tmds_encoder: two instances (default parameters, and zero-pad with inverted syncs)
// compared every clock against an integer-arithmetic model of the TMDS rules, plus directed symbol checks.
module tb_rgb565_tmds_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        de, hs, vs;
  logic [15:0] rgb;
  logic [9:0]  a_ch0, a_ch1, a_ch2, b_ch0, b_ch1, b_ch2;
  logic        a_vld, b_vld;

  int          nvec = 0;
  int          nerr = 0;
  int          cnt_m [2][3];
  logic [29:0] qa[$];
  logic [29:0] qb[$];
  int          edges = 0;

  always #5 clk = ~clk;

  rgb565_tmds_encoder #(.EXPAND_MODE(1'b1), .HS_INVERT(1'b0), .VS_INVERT(1'b0)) u_a (
    .pixel_clk(clk), .sys_rst(rst), .video_hs(hs), .video_vs(vs), .video_de(de), .video_rgb(rgb),
    .tmds_ch0(a_ch0), .tmds_ch1(a_ch1), .tmds_ch2(a_ch2), .tmds_valid(a_vld));

  rgb565_tmds_encoder #(.EXPAND_MODE(1'b0), .HS_INVERT(1'b1), .VS_INVERT(1'b1)) u_b (
    .pixel_clk(clk), .sys_rst(rst), .video_hs(hs), .video_vs(vs), .video_de(de), .video_rgb(rgb),
    .tmds_ch0(b_ch0), .tmds_ch1(b_ch1), .tmds_ch2(b_ch2), .tmds_valid(b_vld));

  function automatic logic [9:0] token(bit c1, bit c0);
    case ({c1, c0})
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // One channel symbol from an 8-bit colour; updates that channel's disparity.
  function automatic logic [9:0] enc_ch(int u, int c, bit [7:0] d, bit den, bit c1, bit c0);
    bit [8:0]   qm;
    bit         inv;
    bit         par;
    int         dis;
    int         cnt;
    logic [9:0] sym;
    if (!den) begin
      cnt_m[u][c] = 0;
      return token(c1, c0);
    end
    inv = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
    par = 1'b0;
    // XOR chain bit i is the prefix parity; the XNOR chain flips it on odd positions.
    for (int i = 0; i < 8; i++) begin
      par   = par ^ d[i];
      qm[i] = par ^ (inv && (i % 2 == 1));
    end
    qm[8] = !inv;
    dis = 2 * $countones(qm[7:0]) - 8;
    cnt = cnt_m[u][c];
    if (cnt == 0 || dis == 0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt = cnt + (qm[8] ? dis : -dis);
    end else if ((cnt > 0 && dis > 0) || (cnt < 0 && dis < 0)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt = cnt + (qm[8] ? 2 : 0) - dis;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt = cnt + dis - (qm[8] ? 0 : 2);
    end
    cnt_m[u][c] = cnt;
    return sym;
  endfunction

  function automatic logic [29:0] enc_px(int u, bit mode, bit hinv, bit vinv,
                                         bit d, bit h, bit v, logic [15:0] p);
    int r5, g6, b5;
    bit [7:0] r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    if (mode) begin
      r8 = 8'((r5 << 3) | (r5 >> 2));
      g8 = 8'((g6 << 2) | (g6 >> 4));
      b8 = 8'((b5 << 3) | (b5 >> 2));
    end else begin
      r8 = 8'(r5 << 3);
      g8 = 8'(g6 << 2);
      b8 = 8'(b5 << 3);
    end
    return {enc_ch(u, 2, r8, d, 1'b0, 1'b0), enc_ch(u, 1, g8, d, 1'b0, 1'b0),
            enc_ch(u, 0, b8, d, v ^ vinv, h ^ hinv)};
  endfunction

  task automatic chk(string tag, logic [29:0] obs, logic [29:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    edges = 0;
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < 3; c++) cnt_m[u][c] = 0;
  endtask

  // Drive one pixel, clock it, then compare both instances with the model.
  task automatic step(bit d, bit h, bit v, logic [15:0] p);
    de  = d;
    hs  = h;
    vs  = v;
    rgb = p;
    @(posedge clk);
    qa.push_back(enc_px(0, 1'b1, 1'b0, 1'b0, d, h, v, p));
    qb.push_back(enc_px(1, 1'b0, 1'b1, 1'b1, d, h, v, p));
    if (qa.size() > 3) void'(qa.pop_front());
    if (qb.size() > 3) void'(qb.pop_front());
    edges++;
    #1;
    chk("valid_a", {29'd0, a_vld}, {29'd0, edges >= 3});
    chk("valid_b", {29'd0, b_vld}, {29'd0, edges >= 3});
    if (edges >= 3) begin
      chk("sym_a", {a_ch2, a_ch1, a_ch0}, qa[0]);
      chk("sym_b", {b_ch2, b_ch1, b_ch0}, qb[0]);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk(tag, {a_ch2, a_ch1, a_ch0}, 30'd0);
    chk(tag, {b_ch2, b_ch1, b_ch0}, 30'd0);
    chk(tag, {28'd0, a_vld, b_vld}, 30'd0);
  endtask

  initial begin
    logic [9:0] lit;
    rst = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = 16'h0000;
    #1 rst = 1'b1;
    #2 chk_reset_outputs("in_reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();

    // Reset release into blanking: valid on the third edge, all channels 0x354.
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("blank_000", {a_ch2, a_ch1, a_ch0}, {10'h354, 10'h354, 10'h354});

    for (int k = 1; k < 4; k++) begin
      for (int n = 0; n < 3; n++) step(1'b0, k[0], k[1], 16'hBEEF);
      chk("ctl_a", {a_ch2, a_ch1, a_ch0}, {10'h354, 10'h354, token(k[1], k[0])});
      chk("ctl_b", {b_ch2, b_ch1, b_ch0}, {10'h354, 10'h354, token(!k[1], !k[0])});
    end

    // Black run, single-cycle gap, black run restarting from 0x100.
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      lit = (i % 2 == 0) ? 10'h100 : 10'h3FF;
      if (i >= 2) begin
        chk("black_a", {a_ch2, a_ch1, a_ch0}, {lit, lit, lit});
        chk("black_b", {b_ch2, b_ch1, b_ch0}, {lit, lit, lit});
      end
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      lit = (i % 2 == 0) ? 10'h100 : 10'h3FF;
      if (i >= 2) chk("black_restart", {a_ch2, a_ch1, a_ch0}, {lit, lit, lit});
    end

    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'hFFFF);
      if (i == 2) chk("white_0", {a_ch2, a_ch1, a_ch0}, {10'h200, 10'h200, 10'h200});
      if (i == 3) chk("white_1", {a_ch2, a_ch1, a_ch0}, {10'h0FF, 10'h0FF, 10'h0FF});
    end

    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'hF800);
    chk("red_rep", {a_ch2, a_ch1, a_ch0}, {10'h200, 10'h100, 10'h100});
    chk("red_pad", {b_ch2, b_ch1, b_ch0}, {10'h2FD, 10'h100, 10'h100});

    repeat (300) step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'($urandom));

    // Reset in the middle of an active line, then black restarts at 0x100.
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 1'b0, 16'h0000);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("mid_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      lit = (i % 2 == 0) ? 10'h100 : 10'h3FF;
      if (i >= 2) chk("post_reset", {a_ch2, a_ch1, a_ch0}, {lit, lit, lit});
    end

    repeat (200) step(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
